// File: rtl/riscv_lsu.sv
// Multicycle load/store unit: alignment check, word-port load extension and
// read-modify-write for sub-word stores. Misaligned accesses park the unit in HALT.
module riscv_lsu #(
  parameter int XLEN        = 32,
  parameter int LANES       = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [XLEN-1:0]    req_addr,
  input  logic [XLEN-1:0]    req_wdata,
  output logic               resp_valid,
  output logic [XLEN-1:0]    resp_rdata,
  output logic               resp_misaligned,
  output logic [XLEN-1:0]    mem_addr,
  input  logic [8*LANES-1:0] mem_data_out,
  output logic [8*LANES-1:0] mem_data_in,
  output logic               mem_write_en,
  output logic               halted,
  output logic [2:0]         o_dbg_state
);

  if (LANES != 4) begin : g_bad_lanes
    $error("riscv_lsu: LANES must be 4");
  end
  if (XLEN != 8 * LANES) begin : g_bad_xlen
    $error("riscv_lsu: XLEN must equal 8*LANES");
  end
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("riscv_lsu: MEM_LATENCY must be at least 1");
  end

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR_WAIT = 3'd2,
    S_RESP    = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  // Handshake: a request is taken on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE, and resp_valid is a single-cycle pulse in RESP.
  state_t            r_state;
  state_t            w_next_state;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_lane;
  logic [15:0]       r_wdata_lo;
  logic              r_mis;
  logic [XLEN-1:0]   r_rdata;
  logic [XLEN-1:0]   r_mem_addr;
  logic [XLEN-1:0]   r_mem_wdata;

  logic              w_misaligned;
  logic              w_last;
  logic              w_waiting;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [XLEN-1:0]   w_load;
  logic [XLEN-1:0]   w_merged;

  assign w_misaligned = (req_size == 2'd3) ||
                        ((req_size == 2'd1) && req_addr[0]) ||
                        ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign w_waiting    = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
  assign w_last       = (r_cnt == CW'(MEM_LATENCY - 1));

  assign w_byte = mem_data_out[{r_lane, 3'b000} +: 8];
  assign w_half = mem_data_out[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load = mem_data_out;
    case (r_size)
      2'd0:    w_load = {{(XLEN-8){~r_unsigned & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{(XLEN-16){~r_unsigned & w_half[15]}}, w_half};
      default: w_load = mem_data_out;
    endcase
  end

  always_comb begin
    w_merged = mem_data_out;
    if (r_size == 2'd0) begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata_lo[7:0];
    end else begin
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata_lo;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_misaligned) begin
            w_next_state = S_RESP;
          end else if (req_we && (req_size == 2'd2)) begin
            w_next_state = S_WR_WAIT;
          end else begin
            w_next_state = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (w_last) begin
          w_next_state = r_we ? S_WR_WAIT : S_RESP;
        end
      end
      S_WR_WAIT: begin
        if (w_last) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP:  w_next_state = r_mis ? S_HALT : S_IDLE;
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_unsigned  <= 1'b0;
      r_lane      <= 2'd0;
      r_wdata_lo  <= '0;
      r_mis       <= 1'b0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_waiting && !w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_wdata_lo <= req_wdata[15:0];
            r_mis      <= w_misaligned;
            r_rdata    <= '0;
            // A rejected access leaves the memory port untouched.
            if (!w_misaligned) begin
              r_mem_addr <= {req_addr[XLEN-1:2], 2'b00};
              if (req_we && (req_size == 2'd2)) begin
                r_mem_wdata <= req_wdata;
              end
            end
          end
        end
        S_RD_WAIT: begin
          if (w_last) begin
            if (r_we) begin
              r_mem_wdata <= w_merged;
            end else begin
              r_rdata <= w_load;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready       = (r_state == S_IDLE);
  assign resp_valid      = (r_state == S_RESP);
  assign resp_misaligned = (r_state == S_RESP) && r_mis;
  assign resp_rdata      = r_rdata;
  assign mem_addr        = r_mem_addr;
  assign mem_data_in     = r_mem_wdata;
  assign mem_write_en    = (r_state == S_WR_WAIT) && w_last;
  assign halted          = (r_state == S_HALT);
  assign o_dbg_state     = r_state;

endmodule
